// File: rtl/ir_key_event_queue.sv
// IR key event queue: validates decoded NEC frames, maps the key byte to a game
// command, tags hold-repeats and buffers events in a first-word-fall-through FIFO.
// Everything runs on clk; ir_data_ready is treated as an asynchronous level.
module ir_key_event_queue #(
  parameter bit               ADDR_CHECK  = 1'b1,
  parameter logic [15:0]      CUSTOM_CODE = 16'h6B86,
  parameter int unsigned      FIFO_AW     = 2,
  parameter int unsigned      CNT_W       = 24,
  parameter int unsigned      HOLD_CYCLES = 6_750_000,
  parameter bit               REPEAT_EN   = 1'b1,
  parameter logic [7:0]       KC_LEFT     = 8'h04,
  parameter logic [7:0]       KC_RIGHT    = 8'h06,
  parameter logic [7:0]       KC_SPIN     = 8'h02,
  parameter logic [7:0]       KC_DOWN     = 8'h08,
  parameter logic [7:0]       KC_DROP     = 8'h05
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ir_data_ready,
  input  logic [31:0] ir_data,
  input  logic        evt_rd,
  output logic        evt_valid,
  output logic [2:0]  evt_key,
  output logic        evt_repeat,
  output logic        frame_err,
  output logic        overflow
);

  localparam int unsigned Depth = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0]   CountFull = (FIFO_AW + 1)'(Depth);
  localparam logic [CNT_W-1:0]   HoldMax   = CNT_W'(HOLD_CYCLES);

  localparam logic [2:0] KeyNone  = 3'd0;
  localparam logic [2:0] KeyLeft  = 3'd1;
  localparam logic [2:0] KeyRight = 3'd2;
  localparam logic [2:0] KeyDown  = 3'd3;
  localparam logic [2:0] KeyDrop  = 3'd4;
  localparam logic [2:0] KeySpin  = 3'd5;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StCheck = 2'd1;
  localparam logic [1:0] StPush  = 2'd2;

  logic [1:0]         sync_q;
  logic               prev_q;
  logic               rise;
  logic [1:0]         state_q, state_d;
  logic [31:0]        frame_q;
  logic               bad;
  logic [2:0]         mapped;
  logic               rep;
  logic [2:0]         mapped_q;
  logic               rep_q;
  logic               frame_err_q;
  logic [2:0]         last_key_q;
  logic [CNT_W-1:0]   hold_cnt_q;
  logic               key_upd;
  logic               push_req;
  logic               do_push;
  logic               do_pop;
  logic               full;
  logic [3:0]         mem [Depth];
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [FIFO_AW:0]   count_q;
  logic               overflow_q;

  assign rise = sync_q[1] & ~prev_q;

  // Two-flop synchroniser plus edge-detect history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], ir_data_ready};
      prev_q <= sync_q[1];
    end
  end

  // Frame validation and key mapping on the captured frame.
  always_comb begin
    bad = (frame_q[23:16] != ~frame_q[31:24]) |
          (ADDR_CHECK && (frame_q[15:0] != CUSTOM_CODE));
    if      (frame_q[23:16] == KC_LEFT)  mapped = KeyLeft;
    else if (frame_q[23:16] == KC_RIGHT) mapped = KeyRight;
    else if (frame_q[23:16] == KC_DOWN)  mapped = KeyDown;
    else if (frame_q[23:16] == KC_DROP)  mapped = KeyDrop;
    else if (frame_q[23:16] == KC_SPIN)  mapped = KeySpin;
    else                                 mapped = KeyNone;
    rep = (mapped == last_key_q) && (hold_cnt_q < HoldMax);
  end

  // FSM next state: one cycle each in CHECK and PUSH; rises outside IDLE are ignored.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (rise) state_d = StCheck;
      StCheck: state_d = bad ? StIdle : StPush;
      StPush:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign key_upd  = (state_q == StPush) && (mapped_q != KeyNone);
  assign push_req = key_upd && (!rep_q || REPEAT_EN);
  assign full     = (count_q == CountFull);
  assign do_pop   = evt_rd && (count_q != '0);
  assign do_push  = push_req && (!full || do_pop);

  // FSM state, frame capture, check results, repeat tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      frame_q     <= '0;
      mapped_q    <= KeyNone;
      rep_q       <= 1'b0;
      frame_err_q <= 1'b0;
      last_key_q  <= KeyNone;
      hold_cnt_q  <= HoldMax;
    end else begin
      state_q     <= state_d;
      frame_err_q <= (state_q == StCheck) && bad;
      if ((state_q == StIdle) && rise) frame_q <= ir_data;
      if ((state_q == StCheck) && !bad) begin
        mapped_q <= mapped;
        rep_q    <= rep;
      end
      if (key_upd) begin
        last_key_q <= mapped_q;
        hold_cnt_q <= '0;
      end else if (hold_cnt_q < HoldMax) begin
        hold_cnt_q <= hold_cnt_q + 1'b1;
      end
    end
  end

  // FIFO storage; contents are don't-care until the count marks them valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= {mapped_q, rep_q};
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (!do_push && do_pop) count_q <= count_q - 1'b1;
      if (push_req && full && !do_pop) overflow_q <= 1'b1;
    end
  end

  // Head entry drives the outputs; zero while empty.
  always_comb begin
    evt_valid  = (count_q != '0);
    evt_key    = evt_valid ? mem[rptr_q][3:1] : KeyNone;
    evt_repeat = evt_valid ? mem[rptr_q][0] : 1'b0;
    frame_err  = frame_err_q;
    overflow   = overflow_q;
  end

endmodule

// File: tb/tb_ir_key_event_queue.sv
// Bench for ir_key_event_queue: table-driven frames with a scoreboard queue of
// expected events, plus hand sequences for latency, FIFO full and reset corners.
module tb_ir_key_event_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        ir_data_ready;
  logic [31:0] ir_data;
  logic        evt_rd, rd_nr, rd_na;
  logic        evt_valid, evt_repeat, frame_err, overflow;
  logic [2:0]  evt_key;
  logic        nr_valid, nr_repeat, nr_err, nr_ovf;
  logic [2:0]  nr_key;
  logic        na_valid, na_repeat, na_err, na_ovf;
  logic [2:0]  na_key;

  always #5 clk = ~clk;

  ir_key_event_queue #(.HOLD_CYCLES(1000)) dut (
    .clk(clk), .rst(rst), .ir_data_ready(ir_data_ready), .ir_data(ir_data), .evt_rd(evt_rd),
    .evt_valid(evt_valid), .evt_key(evt_key), .evt_repeat(evt_repeat),
    .frame_err(frame_err), .overflow(overflow)
  );

  ir_key_event_queue #(.HOLD_CYCLES(1000), .REPEAT_EN(1'b0)) dut_nr (
    .clk(clk), .rst(rst), .ir_data_ready(ir_data_ready), .ir_data(ir_data), .evt_rd(rd_nr),
    .evt_valid(nr_valid), .evt_key(nr_key), .evt_repeat(nr_repeat),
    .frame_err(nr_err), .overflow(nr_ovf)
  );

  ir_key_event_queue #(.HOLD_CYCLES(1000), .ADDR_CHECK(1'b0)) dut_na (
    .clk(clk), .rst(rst), .ir_data_ready(ir_data_ready), .ir_data(ir_data), .evt_rd(rd_na),
    .evt_valid(na_valid), .evt_key(na_key), .evt_repeat(na_repeat),
    .frame_err(na_err), .overflow(na_ovf)
  );

  typedef struct {
    bit          do_rst;
    int          gap;
    logic [31:0] frame;
    int          err;
    bit          push;
    logic [2:0]  key;
    logic        rep;
  } vec_t;

  vec_t       vecs[11];
  logic [3:0] sb[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    ir_data_ready = 1'b0;
    evt_rd = 1'b0;
    #1;
    check("reset_outputs", {1'b0, evt_valid, evt_key, evt_repeat, frame_err, overflow}, 8'h00);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // One frame: ready high for 6 cycles then low for 6; counts frame_err pulses.
  task automatic send_frame(input logic [31:0] f, output int errs);
    errs = 0;
    ir_data = f;
    ir_data_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      errs += int'(frame_err);
    end
    ir_data_ready = 1'b0;
    repeat (6) begin
      @(negedge clk);
      errs += int'(frame_err);
    end
  endtask

  // Pop every expected event from the main DUT and compare against the scoreboard.
  task automatic drain(input string name);
    logic [3:0] exp;
    while (sb.size() > 0) begin
      for (int t = 0; t < 40 && !evt_valid; t++) @(negedge clk);
      exp = sb.pop_front();
      check({name, "_evt"}, {4'b0, evt_valid, evt_key, evt_repeat}, {4'b0, 1'b1, exp});
      evt_rd = 1'b1;
      @(negedge clk);
      evt_rd = 1'b0;
    end
    check({name, "_empty"}, {7'b0, evt_valid}, 8'h00);
  endtask

  task automatic run_rows(input int lo, input int hi);
    int errs;
    for (int i = lo; i <= hi; i++) begin
      if (vecs[i].do_rst) do_reset();
      repeat (vecs[i].gap) @(negedge clk);
      send_frame(vecs[i].frame, errs);
      check($sformatf("row%0d_err", i), 8'(errs), 8'(vecs[i].err));
      if (vecs[i].push) sb.push_back({vecs[i].key, vecs[i].rep});
      drain($sformatf("row%0d", i));
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int         errs;
    logic [3:0] exp;

    vecs[0]  = '{1, 5,    32'hFB04_6B86, 0, 1, 3'd1, 1'b0};
    vecs[1]  = '{0, 100,  32'hFB04_6B86, 0, 1, 3'd1, 1'b1};
    vecs[2]  = '{0, 1200, 32'hFB04_6B86, 0, 1, 3'd1, 1'b0};
    vecs[3]  = '{1, 5,    32'hFA04_6B86, 1, 0, 3'd0, 1'b0};
    vecs[4]  = '{0, 5,    32'hFB04_1234, 1, 0, 3'd0, 1'b0};
    vecs[5]  = '{1, 5,    32'hF906_6B86, 0, 1, 3'd2, 1'b0};
    vecs[6]  = '{0, 5,    32'hF609_6B86, 0, 0, 3'd0, 1'b0};
    vecs[7]  = '{0, 5,    32'hFB04_6B86, 0, 1, 3'd1, 1'b0};
    vecs[8]  = '{0, 5,    32'hF708_6B86, 0, 1, 3'd3, 1'b0};
    vecs[9]  = '{0, 5,    32'hFA05_6B86, 0, 1, 3'd4, 1'b0};
    vecs[10] = '{0, 5,    32'hFD02_6B86, 0, 1, 3'd5, 1'b0};

    rst = 1'b0;
    ir_data_ready = 1'b0;
    ir_data = '0;
    evt_rd = 1'b0;
    rd_nr = 1'b0;
    rd_na = 1'b0;
    do_reset();

    // Latency: synced rise at the 2nd edge, event visible after the 5th.
    ir_data = 32'hFB04_6B86;
    ir_data_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("lat_before", {7'b0, evt_valid}, 8'h00);
    @(negedge clk);
    check("lat_at", {4'b0, evt_valid, evt_key, evt_repeat}, {4'b0, 1'b1, 3'd1, 1'b0});
    ir_data_ready = 1'b0;
    repeat (6) @(negedge clk);
    sb.push_back({3'd1, 1'b0});
    drain("lat");

    // Repeat window; REPEAT_EN=0 instance keeps only the two non-repeats.
    run_rows(0, 2);
    check("nr_head0", {4'b0, nr_valid, nr_key, nr_repeat}, {4'b0, 1'b1, 3'd1, 1'b0});
    rd_nr = 1'b1;
    @(negedge clk);
    rd_nr = 1'b0;
    check("nr_head1", {4'b0, nr_valid, nr_key, nr_repeat}, {4'b0, 1'b1, 3'd1, 1'b0});
    rd_nr = 1'b1;
    @(negedge clk);
    rd_nr = 1'b0;
    check("nr_empty", {7'b0, nr_valid}, 8'h00);

    // Bad inverse and bad custom code; ADDR_CHECK=0 instance accepts the latter.
    run_rows(3, 4);
    check("na_head", {4'b0, na_valid, na_key, na_repeat}, {4'b0, 1'b1, 3'd1, 1'b0});
    rd_na = 1'b1;
    @(negedge clk);
    rd_na = 1'b0;
    check("na_empty", {7'b0, na_valid}, 8'h00);

    // Unmapped key leaves last_key alone; remaining mappings.
    run_rows(5, 10);

    // FIFO full, pop+push at full, then overflow on a push with no pop.
    do_reset();
    send_frame(32'hFB04_6B86, errs); sb.push_back({3'd1, 1'b0});
    send_frame(32'hF906_6B86, errs); sb.push_back({3'd2, 1'b0});
    send_frame(32'hFD02_6B86, errs); sb.push_back({3'd5, 1'b0});
    send_frame(32'hF708_6B86, errs); sb.push_back({3'd3, 1'b0});
    check("full_valid", {7'b0, evt_valid}, 8'h01);
    check("full_no_ovf", {7'b0, overflow}, 8'h00);
    ir_data = 32'hFA05_6B86;
    ir_data_ready = 1'b1;
    repeat (4) @(negedge clk);
    evt_rd = 1'b1;
    exp = sb.pop_front();
    check("pp_head", {4'b0, evt_valid, evt_key, evt_repeat}, {4'b0, 1'b1, exp});
    @(negedge clk);
    evt_rd = 1'b0;
    ir_data_ready = 1'b0;
    repeat (6) @(negedge clk);
    sb.push_back({3'd4, 1'b0});
    check("pp_no_ovf", {7'b0, overflow}, 8'h00);
    send_frame(32'hFB04_6B86, errs);
    check("ovf_set", {7'b0, overflow}, 8'h01);
    drain("fifo_order");
    check("ovf_sticky", {7'b0, overflow}, 8'h01);

    // Reset during CHECK: frame lost, next identical frame is not a repeat.
    do_reset();
    send_frame(32'hFD02_6B86, errs);
    sb.push_back({3'd5, 1'b0});
    drain("pre_rst");
    ir_data = 32'hFD02_6B86;
    ir_data_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    ir_data_ready = 1'b0;
    #1;
    check("rst_in_check", {1'b0, evt_valid, evt_key, evt_repeat, frame_err, overflow}, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    check("frame_lost", {6'b0, evt_valid, frame_err}, 8'h00);
    send_frame(32'hFD02_6B86, errs);
    sb.push_back({3'd5, 1'b0});
    drain("post_rst_check");

    // Reset with three queued events.
    send_frame(32'hFB04_6B86, errs);
    send_frame(32'hF906_6B86, errs);
    send_frame(32'hFD02_6B86, errs);
    check("three_queued", {7'b0, evt_valid}, 8'h01);
    rst = 1'b0;
    #1;
    check("rst_queued", {1'b0, evt_valid, evt_key, evt_repeat, frame_err, overflow}, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send_frame(32'hFD02_6B86, errs);
    sb.push_back({3'd5, 1'b0});
    drain("post_rst_fifo");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
